// File: rtl/chan_sel_pipe.sv
// chan_sel_pipe: runtime-selectable N-channel pass-through with a registered output
// stage. The output is drained before the selection changes.
module chan_sel_pipe #(
    parameter int NCH = 3,
    parameter int WIDTH = 8,
    parameter int DEFAULT_SEL = 0,
    localparam int SW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 sel_req_valid,
    input  logic [SW-1:0]        sel_req_idx,
    output logic                 sel_req_ready,
    output logic [SW-1:0]        sel_cur,
    output logic                 switching,
    output logic                 sel_err
);
    typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

    state_t           r_state, w_state_nxt;
    logic [SW-1:0]    r_sel, r_pend;
    logic [WIDTH-1:0] r_out_data, w_sel_data;
    logic             r_out_valid, r_err;
    logic             w_rdy, w_xfer, w_req_ok, w_req_bad;
    logic [NCH-1:0]   w_in_ready;

    always_comb begin
        w_rdy      = (r_state == RUN) && (!r_out_valid || out_ready);
        w_sel_data = '0;
        w_in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            w_in_ready[k] = w_rdy && (r_sel == SW'(k));
            if (r_sel == SW'(k)) w_sel_data = in_data[k*WIDTH +: WIDTH];
        end
        w_xfer    = |(w_in_ready & in_valid);
        w_req_ok  = (r_state == RUN) && sel_req_valid && (32'(sel_req_idx) < NCH);
        w_req_bad = (r_state == RUN) && sel_req_valid && (32'(sel_req_idx) >= NCH);
    end

    // DRAIN leaves on the first edge that sees the output stage empty.
    always_comb begin
        w_state_nxt = (r_state == RUN    && w_req_ok)     ? DRAIN  :
                      (r_state == DRAIN  && !r_out_valid) ? SWITCH :
                      (r_state == SWITCH)                 ? RUN    : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= SW'(DEFAULT_SEL);
            r_pend      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_sel_data;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_req_ok) r_pend <= sel_req_idx;
            if (w_req_bad) r_err <= 1'b1;
            if (r_state == SWITCH) r_sel <= r_pend;
        end
    end

    assign in_ready      = w_in_ready;
    assign out_data      = r_out_data;
    assign out_valid     = r_out_valid;
    assign sel_req_ready = (r_state == RUN);
    assign sel_cur       = r_sel;
    assign switching     = (r_state != RUN);
    assign sel_err       = r_err;
endmodule

// File: doc/chan_sel_pipe.md
# chan_sel_pipe

Runtime-selectable N-channel pass-through with a registered output stage. Replaces compile-time branch selection, where one input/output pair is chosen at elaboration, with a channel index that changes during operation. Each input channel has a valid/ready handshake. A selection change is itself a handshake and only takes effect once the output stage has drained, so no beat from the old channel can follow a beat from the new one. The block sits between per-source channel producers and a single downstream consumer.

## Interface
Parameters:
- NCH, 3, number of input channels (≥2)
- WIDTH, 8, data width per channel
- DEFAULT_SEL, 0, channel selected after reset (must be < NCH)
- SW = $clog2(NCH), derived, select index width

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready
- out_data  output  WIDTH  registered output data
- out_valid  output  1  output valid
- out_ready  input  1  downstream ready
- sel_req_valid  input  1  selection change request
- sel_req_idx  input  SW  requested channel
- sel_req_ready  output  1  request accepted when high with sel_req_valid
- sel_cur  output  SW  currently selected channel
- switching  output  1  high while in DRAIN or SWITCH
- sel_err  output  1  sticky flag, set by an out-of-range request

## Operation
- States: RUN, DRAIN, SWITCH. Reset state is RUN.
- Reset values:
  - sel_cur = DEFAULT_SEL
  - out_valid = 0
  - out_data = 0
  - sel_err = 0
  - switching = 0
  - internal pending index = 0
- RUN:
  - in_ready[sel_cur] = !out_valid || out_ready. All other in_ready bits are 0.
  - A transfer occurs on in_valid[sel_cur] && in_ready[sel_cur]: out_data <= that channel's slice, out_valid <= 1.
  - If out_valid && out_ready and no transfer occurs, out_valid <= 0.
- sel_req_ready = 1 only in RUN.
- Request accepted in RUN with sel_req_idx < NCH: pending <= sel_req_idx, go to DRAIN.
  - An input transfer in the same cycle still completes.
- Request accepted in RUN with sel_req_idx ≥ NCH (only possible when NCH is not a power of two): sel_err <= 1, stay in RUN, sel_cur unchanged.
- DRAIN:
  - All in_ready = 0. The output stage keeps handshaking normally.
  - Go to SWITCH on the edge where out_valid is 0. If out_valid is already 0 on entry, DRAIN lasts exactly one cycle.
- SWITCH: all in_ready = 0, sel_cur <= pending, go to RUN. Lasts exactly one cycle.
- A request for the index already selected still runs the full DRAIN/SWITCH sequence. This keeps timing deterministic.
- switching = (state != RUN), decoded combinationally from the state register.
- in_valid on non-selected channels is ignored. Their data is never sampled.
- sel_err is cleared only by reset.

## Timing
- Data latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle while out_ready is held high.
- in_ready depends combinationally on out_ready and state only. It never depends on in_valid.
- Switch latency, request accepted at edge t with the output empty:
  - DRAIN during cycle t..t+1
  - SWITCH during t+1..t+2
  - new sel_cur and in_ready[new] visible after edge t+2
- Each extra cycle the output stays valid in DRAIN adds one cycle to the switch latency.
- out_data and out_valid are held stable while out_valid && !out_ready.
- Reset asserted mid-switch: immediate return to RUN with sel_cur = DEFAULT_SEL. The pending index is discarded and the output is emptied.

## Test plan
- Reset, then drive ch0 with 0x11, 0x22, 0x33 back-to-back, out_ready=1.
  - out_data = 0x11, 0x22, 0x33 on consecutive cycles, one cycle after each input.
  - in_ready = 3'b001 throughout.
- Backpressure: out_ready=0 with 0xA5 held in the output.
  - in_ready[0] = 0, out_data stays 0xA5.
  - When out_ready rises, the next beat is accepted the same cycle.
- Switch to ch2 with the output empty, request at edge t.
  - switching is high for 2 cycles.
  - sel_cur = 2 after edge t+2.
  - in_ready goes 001 → 000 → 000 → 100.
  - ch1 asserting in_valid throughout produces no output.
- Switch requested while 0x5A sits in the output and out_ready is low for 3 cycles.
  - DRAIN holds 4 cycles.
  - No ch1 beat appears before 0x5A is consumed.
- NCH=3, request idx 3.
  - sel_err = 1, sel_cur unchanged, no state change.
  - A later valid request still works.
- Reset asserted during DRAIN.
  - sel_cur = DEFAULT_SEL, out_valid = 0, switching = 0 immediately.
- Same-index request (idx = sel_cur).
  - switching is high for 2 cycles, sel_cur unchanged afterwards.
